seq_mult_param: RTL and testbench

- Parametrised iterative shift-add multiplier. It is the successor to the fixed 8x8 unsigned lab multiplier.
- Operand width is a parameter. Signed or unsigned mode is chosen per operation.
- Uses an explicit start/busy/out_valid handshake, so a new operation can begin without asserting reset.
- Sits between operand registers and a result consumer. One multiply is in flight at a time.

---
 rtl/seq_mult_param.sv | 79 +++++++
 tb/tb_seq_mult_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative signed/unsigned shift-add multiplier; SEQ_MULT_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are zero
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mag_a, mag_b, mcand, mplier;
  logic [WIDTH:0] upper;
  logic [2*WIDTH:0] acc, acc_nx, acc_fin;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0] cnt;
  logic neg, accept, last, zero_skip;
  // operand magnitudes; the most negative value wraps to 2^(WIDTH-1) read as unsigned
  always_comb begin
    mag_a = (is_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b = (is_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    accept = start && state != CALC;
  end
  // one shift-add step, the exit test and the signed result it would produce
  always_comb begin
    upper = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nx = {upper, acc[WIDTH-1:0]} >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    last = mplier[WIDTH-1:1] == '0;
    acc_fin = acc_nx >> (cnt - 1'b1);
    zero_skip = mag_b == '0;
`else
    last = cnt == CNT_W'(1);
    acc_fin = acc_nx;
    zero_skip = 1'b0;
`endif
    prod = neg ? -acc_fin[2*WIDTH-1:0] : acc_fin[2*WIDTH-1:0];
  end
  // state register
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next state: DONE falls back to IDLE unless a new start is accepted
  always_comb
    state_nx = accept ? (zero_skip ? DONE : CALC) : (state == CALC) ? (last ? DONE : CALC) : IDLE;
  // outputs decoded from state
  always_comb begin
    busy = state == CALC;
    out_valid = state == DONE;
  end
  // datapath: latch on accept, iterate in CALC, publish the product on the final step
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      out <= '0;
    end else if (accept) begin
      mcand <= mag_a;
      mplier <= mag_b;
      acc <= '0;
      cnt <= CNT_W'(WIDTH);
      neg <= is_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      if (zero_skip) out <= '0;
    end else if (state == CALC) begin
      acc <= acc_nx;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
      if (last) out <= prod;
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: table vectors and corner sequences on 8-bit and 16-bit instances, scoreboard on out_valid
module tb_seq_mult_param;
  logic CLK = 0, reset_n = 0;
  logic start8 = 0, sg8 = 0, busy8, ov8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] out8;
  logic start16 = 0, sg16 = 0, busy16, ov16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] out16;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [31:0] exp; int due;} sb_t;
  typedef struct {logic s; logic [7:0] a; logic [7:0] b; logic [15:0] exp;} vec_t;
  sb_t sb8[$], sb16[$];
  vec_t tv[12];

  seq_mult_param #(.WIDTH(8)) dut8 (.CLK(CLK), .reset_n(reset_n), .start(start8), .is_signed(sg8),
    .in_a(a8), .in_b(b8), .busy(busy8), .out(out8), .out_valid(ov8));
  seq_mult_param #(.WIDTH(16)) dut16 (.CLK(CLK), .reset_n(reset_n), .start(start16), .is_signed(sg16),
    .in_a(a16), .in_b(b16), .busy(busy16), .out(out16), .out_valid(ov16));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int w, input logic [31:0] mag);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int h = -1;
    for (int i = 0; i < w; i++) if (mag[i]) h = i;
    return h < 0 ? 1 : h + 2;
`else
    return w + 1;
`endif
  endfunction

  function automatic logic [31:0] mul16(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint sa = s ? longint'($signed(a)) : longint'(a);
    longint sb = s ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  always @(negedge CLK) if (reset_n && ov8) begin
    sb_t e;
    if (sb8.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious out_valid8: got out=%0h, no result pending", out8);
    end else begin
      e = sb8.pop_front();
      chk("out8", 32'(out8), e.exp);
      chk("latency8", 32'(cyc), 32'(e.due));
    end
  end

  always @(negedge CLK) if (reset_n && ov16) begin
    sb_t e;
    if (sb16.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious out_valid16: got out=%0h, no result pending", out16);
    end else begin
      e = sb16.pop_front();
      chk("out16", out16, e.exp);
      chk("latency16", 32'(cyc), 32'(e.due));
    end
  end

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    logic [7:0] m;
    int l, nb, k;
    m = (s && b[7]) ? -b : b;
    l = lat_of(8, 32'(m));
    @(negedge CLK);
    sg8 = s; a8 = a; b8 = b; start8 = 1;
    sb8.push_back('{32'(exp), cyc + l});
    @(negedge CLK);
    start8 = 0;
    nb = 0;
    for (k = 0; k < 100 && sb8.size() != 0; k++) begin
      if (busy8) nb++;
      @(negedge CLK);
    end
    chk("done8 in time", 32'(k < 100), 1);
    if (k == 100) sb8.delete();
    chk("busy8 cycles", 32'(nb), 32'(l - 1));
  endtask

  task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    logic [15:0] m;
    int l, nb, k;
    m = (s && b[15]) ? -b : b;
    l = lat_of(16, 32'(m));
    @(negedge CLK);
    sg16 = s; a16 = a; b16 = b; start16 = 1;
    sb16.push_back('{exp, cyc + l});
    @(negedge CLK);
    start16 = 0;
    nb = 0;
    for (k = 0; k < 100 && sb16.size() != 0; k++) begin
      if (busy16) nb++;
      @(negedge CLK);
    end
    chk("done16 in time", 32'(k < 100), 1);
    if (k == 100) sb16.delete();
    chk("busy16 cycles", 32'(nb), 32'(l - 1));
  endtask

  task automatic drain8(input string name);
    int k;
    for (k = 0; k < 100 && sb8.size() != 0; k++) @(negedge CLK);
    chk(name, 32'(k < 100), 1);
    if (k == 100) sb8.delete();
  endtask

  initial begin
    logic s;
    logic [15:0] ra, rb;
    int k;
    tv = '{
      '{1'b0, 8'd3,   8'd9,   16'd27},
      '{1'b0, 8'd255, 8'd255, 16'd65025},
      '{1'b1, 8'h80,  8'h80,  16'd16384},
      '{1'b1, 8'h80,  8'd127, 16'hC080},
      '{1'b1, 8'd25,  8'd0,   16'd0},
      '{1'b1, 8'hFF,  8'hFF,  16'd1},
      '{1'b1, 8'hFF,  8'd1,   16'hFFFF},
      '{1'b0, 8'hFF,  8'd1,   16'd255},
      '{1'b0, 8'd128, 8'd2,   16'd256},
      '{1'b0, 8'd0,   8'd200, 16'd0},
      '{1'b1, 8'd0,   8'h80,  16'd0},
      '{1'b1, 8'd7,   8'hFD,  16'hFFEB}
    };
    repeat (3) @(negedge CLK);
    reset_n = 1;
    chk("reset busy8", 32'(busy8), 0);
    chk("reset out8", 32'(out8), 0);
    chk("reset out_valid8", 32'(ov8), 0);
    chk("reset busy16", 32'(busy16), 0);
    chk("reset out16", out16, 0);
    chk("reset out_valid16", 32'(ov16), 0);

    run8(1'b0, 8'd3, 8'd9, 16'd27);
    repeat (3) @(negedge CLK);
    chk("out8 holds", 32'(out8), 27);
    chk("out_valid8 low after pulse", 32'(ov8), 0);

    for (int i = 0; i < 12; i++) run8(tv[i].s, tv[i].a, tv[i].b, tv[i].exp);

    // back-to-back: start held high through DONE with new operands
    @(negedge CLK);
    sg8 = 0; a8 = 8'd45; b8 = 8'd69; start8 = 1;
    sb8.push_back('{32'd3105, cyc + lat_of(8, 32'd69)});
    for (k = 0; k < 100 && !ov8; k++) @(negedge CLK);
    chk("b2b first done", 32'(k < 100), 1);
    a8 = 8'd100; b8 = 8'd14;
    sb8.push_back('{32'd1400, cyc + lat_of(8, 32'd14)});
    @(negedge CLK);
    start8 = 0;
    drain8("b2b second done");

    // start and operand changes mid-CALC are ignored
    @(negedge CLK);
    sg8 = 0; a8 = 8'd45; b8 = 8'd69; start8 = 1;
    sb8.push_back('{32'd3105, cyc + lat_of(8, 32'd69)});
    @(negedge CLK);
    start8 = 0;
    repeat (2) @(negedge CLK);
    sg8 = 1; a8 = 8'd1; b8 = 8'hFF; start8 = 1;
    @(negedge CLK);
    start8 = 0;
    drain8("ignored start done");
    repeat (12) @(negedge CLK);

    // asynchronous reset during the 4th CALC cycle
    @(negedge CLK);
    sg8 = 0; a8 = 8'd200; b8 = 8'd200; start8 = 1;
    sb8.push_back('{32'd40000, cyc + lat_of(8, 32'd200)});
    @(negedge CLK);
    start8 = 0;
    repeat (3) @(negedge CLK);
    #1 reset_n = 0;
    #1;
    chk("midreset busy8", 32'(busy8), 0);
    chk("midreset out8", 32'(out8), 0);
    chk("midreset out_valid8", 32'(ov8), 0);
    sb8.delete();
    @(negedge CLK);
    reset_n = 1;
    run8(1'b0, 8'd123, 8'd12, 16'd1476);

    // 16-bit: -300 * 1234 = -370200
    run16(1'b1, 16'hFED4, 16'd1234, 32'hFFFA59E8);
    run16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      run16(s, ra, rb, mul16(s, ra, rb));
    end

    repeat (5) @(negedge CLK);
    chk("sb8 drained", 32'(sb8.size()), 0);
    chk("sb16 drained", 32'(sb16.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
